fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- IF-stage PC generator and instruction-fetch sequencer of the 5-stage MIPS pipeline; the consumer of the ID-stage branch-taken decision and target.
- Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents fetched instructions to the IF/ID register.
- Applies branch redirects with MIPS delay-slot semantics and exception redirects with an IF flush.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- EXC_VECTOR, 32'h0040_0004, redirect target on in_exception.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  asynchronous, active-low reset.
- in_stall  input  1  downstream hazard stall; hold IF output.
- in_branch  input  1  ID-stage branch/jump taken, single-cycle pulse.
- in_branch_target  input  32  redirect PC, valid with in_branch.
- in_exception  input  1  exception redirect request, single-cycle pulse.
- out_imem_req  output  1  fetch request.
- out_imem_addr  output  32  fetch word address, bits[1:0] always 0.
- in_imem_ack  input  1  fetch complete; in_imem_data valid this cycle.
- in_imem_data  input  32  fetched instruction.
- out_if_valid  output  1  out_if_instr/out_if_pc hold a live instruction.
- out_if_instr  output  32  instruction to IF/ID.
- out_if_pc  output  32  PC of out_if_instr.
- out_flush  output  1  one-cycle pulse: kill IF/ID contents.

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, state S_IDLE, out_imem_req=0, out_if_valid=0, out_if_instr=0, out_if_pc=0, out_flush=0, pending redirect cleared.
- States: S_IDLE, S_FETCH, S_HOLD.
- S_IDLE: one cycle after reset release, then go to S_FETCH.
- S_FETCH: out_imem_req=1, out_imem_addr=PC; address stable until ack. On in_imem_ack:
  - capture data and PC into the IF outputs and set out_if_valid=1; same-cycle latency from ack to registered output (visible next cycle).
  - PC <= pending target if a redirect is pending (then clear it), else PC+4.
  - stay in S_FETCH if in_stall=0, else go to S_HOLD.
- S_HOLD: out_imem_req=0, IF outputs frozen. Return to S_FETCH in the first cycle in_stall=0.
- Branch (in_branch=1, in_exception=0): the instruction currently fetched or in flight is the delay slot and is kept; no flush.
  - If no fetch is in flight, PC <= in_branch_target immediately.
  - Otherwise latch the target as pending; it is applied at the ack.
- Exception: out_flush=1 the next cycle, out_if_valid<=0, pending cleared, PC <= EXC_VECTOR.
  - If a fetch is in flight, its ack data is discarded (kill flag), then fetch EXC_VECTOR.
  - Exception has priority over a simultaneous branch.
- Stall plus branch in the same cycle: the target is still latched; the stall never drops a redirect.
- Second branch while one is pending: the newer target overwrites the pending one.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- in_branch_target[1:0] is forced to 0.
- Reset asserted mid-fetch: the request drops immediately; a late ack is ignored until state is S_FETCH again.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output out_redirect_cnt (32) counting applied branch and exception redirects, and output out_stall_cnt (32) counting cycles in S_HOLD plus cycles in S_FETCH waiting for ack. Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package mips_def.vh gets:
  - state encodings FETCH_S_IDLE, FETCH_S_FETCH, FETCH_S_HOLD.
  - default RESET_PC and EXC_VECTOR values.
  - the INSTR_NOP encoding 32'h0000_0000.
- One natural sub-module, pc_redirect_reg: holds the pending-target register, the kill flag and the priority logic. The FSM stays in the top module.

Test Plan:
- Reset release, memory with 1-cycle ack -> fetch addresses 0x00400000, 0x00400004, 0x00400008; out_if_valid rises after the first ack.
- in_branch with in_branch_target=0x00400100 while fetching 0x00400008 -> 0x00400008 is delivered (delay slot), next fetch address is 0x00400100, out_flush stays 0.
- in_exception while fetch 0x0040000C awaits a 3-cycle ack -> out_flush pulses, ack data discarded, next fetch address is 0x00400004, out_if_valid=0 until that returns.
- Simultaneous in_branch (target 0x00400200) and in_exception -> redirect to 0x00400004 only; no later fetch of 0x00400200.
- in_stall held 4 cycles after an ack -> IF outputs unchanged, out_imem_req=0, fetching resumes at PC+4; with FETCH_PERF_CNT_EN, out_stall_cnt rises by 4.
- in_branch_target=0xFFFFFFFC, then a sequential fetch -> fetch addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF-stage PC generator and fetch sequencer.
// State encodings, default vectors and the IF/ID payload type.
package fetch_pc_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h0040_0004;
    localparam logic [XLEN-1:0] INSTR_NOP      = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP        = 32'd4;

    typedef enum logic [1:0] {
        FETCH_S_IDLE  = 2'd0,
        FETCH_S_FETCH = 2'd1,
        FETCH_S_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_bundle_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_redirect_reg.sv
// Pending branch target, in-flight kill flag and redirect priority.
// Exception beats branch; a branch during an in-flight fetch waits for its ack.
module pc_redirect_reg
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetching,
    input  logic            ack,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            exception,
    output logic            load_c,
    output logic [XLEN-1:0] target_c,
    output logic            capture_c
);

    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            kill_q, kill_d;
    logic            done;
    logic [XLEN-1:0] br_tgt;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        kill_d        = kill_q;
        load_c        = 1'b0;
        target_c      = pend_target_q;
        capture_c     = 1'b0;
        done          = fetching && ack;
        br_tgt        = word_align(branch_target);

        if (exception) begin
            pend_valid_d = 1'b0;
            // An outstanding request keeps its address; its data is dropped later.
            if (fetching && !ack) begin
                kill_d = 1'b1;
            end else begin
                kill_d   = 1'b0;
                load_c   = 1'b1;
                target_c = word_align(EXC_VECTOR);
            end
        end else if (kill_q) begin
            if (done) begin
                kill_d   = 1'b0;
                load_c   = 1'b1;
                target_c = word_align(EXC_VECTOR);
            end
        end else if (done) begin
            capture_c    = 1'b1;
            pend_valid_d = 1'b0;
            if (branch) begin
                load_c   = 1'b1;
                target_c = br_tgt;
            end else if (pend_valid_q) begin
                load_c   = 1'b1;
                target_c = pend_target_q;
            end
        end else if (branch) begin
            if (fetching) begin
                pend_valid_d  = 1'b1;
                pend_target_d = br_tgt;
            end else begin
                load_c   = 1'b1;
                target_c = br_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            kill_q        <= kill_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator and instruction-fetch sequencer (req/ack imem port).
// Build option FETCH_PERF_CNT_EN adds redirect and stall counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_stall,
    input  logic        in_branch,
    input  logic [31:0] in_branch_target,
    input  logic        in_exception,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ack,
    input  logic [31:0] in_imem_data,
    output logic        out_if_valid,
    output logic [31:0] out_if_instr,
    output logic [31:0] out_if_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] out_redirect_cnt,
    output logic [31:0] out_stall_cnt,
`endif
    output logic        out_flush
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            flush_q, flush_d;
    if_bundle_t      if_q, if_d;

    logic            fetching;
    logic            redir_load_c;
    logic [XLEN-1:0] redir_target_c;
    logic            capture_c;

    assign fetching = (state_q == FETCH_S_FETCH);

    pc_redirect_reg #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_redirect (
        .clk          (in_clk),
        .rst_n        (in_rst),
        .fetching     (fetching),
        .ack          (in_imem_ack),
        .branch       (in_branch),
        .branch_target(in_branch_target),
        .exception    (in_exception),
        .load_c       (redir_load_c),
        .target_c     (redir_target_c),
        .capture_c    (capture_c)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if_d    = if_q;
        flush_d = in_exception;

        case (state_q)
            FETCH_S_IDLE:  state_d = FETCH_S_FETCH;
            FETCH_S_FETCH: if (in_imem_ack) state_d = in_stall ? FETCH_S_HOLD : FETCH_S_FETCH;
            FETCH_S_HOLD:  if (!in_stall) state_d = FETCH_S_FETCH;
            default:       state_d = FETCH_S_IDLE;
        endcase

        if (redir_load_c) begin
            pc_d = redir_target_c;
        end else if (fetching && in_imem_ack) begin
            pc_d = pc_q + PC_STEP;
        end

        if (capture_c) begin
            if_d    = '{instr: in_imem_data, pc: pc_q};
            valid_d = 1'b1;
        end
        if (in_exception) begin
            valid_d = 1'b0;
        end

        req_d = (state_d == FETCH_S_FETCH);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= FETCH_S_IDLE;
            pc_q    <= word_align(RESET_PC);
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            if_q    <= '{instr: INSTR_NOP, pc: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            if_q    <= if_d;
        end
    end

    assign out_imem_req  = req_q;
    assign out_imem_addr = pc_q;
    assign out_if_valid  = valid_q;
    assign out_if_instr  = if_q.instr;
    assign out_if_pc     = if_q.pc;
    assign out_flush     = flush_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters: applied redirects and cycles not delivering.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redir_load_c && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + XLEN'(1);
        end
        if (((state_q == FETCH_S_HOLD) || (fetching && !in_imem_ack)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign out_redirect_cnt = redirect_cnt_q;
    assign out_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h0040_0004;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD  = 2;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_stall;
    logic        in_branch;
    logic [31:0] in_branch_target;
    logic        in_exception;
    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ack;
    logic [31:0] in_imem_data;
    logic        out_if_valid;
    logic [31:0] out_if_instr;
    logic [31:0] out_if_pc;
    logic        out_flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] out_redirect_cnt;
    logic [31:0] out_stall_cnt;
    logic [31:0] stall_snap;
`endif

    fetch_pc_unit dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_stall        (in_stall),
        .in_branch       (in_branch),
        .in_branch_target(in_branch_target),
        .in_exception    (in_exception),
        .out_imem_req    (out_imem_req),
        .out_imem_addr   (out_imem_addr),
        .in_imem_ack     (in_imem_ack),
        .in_imem_data    (in_imem_data),
        .out_if_valid    (out_if_valid),
        .out_if_instr    (out_if_instr),
        .out_if_pc       (out_if_pc),
`ifdef FETCH_PERF_CNT_EN
        .out_redirect_cnt(out_redirect_cnt),
        .out_stall_cnt   (out_stall_cnt),
`endif
        .out_flush       (out_flush)
    );

    always #5 in_clk = ~in_clk;

    // Reference model: architectural view of the fetch unit
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic        m_flush;
    logic        m_kill;
    logic [31:0] m_pend[$];

    int lat;
    int wait_cnt;
    bit ack_force;
    int n_vec;
    int n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = RST_PC;
        m_instr = 32'h0;
        m_ifpc  = 32'h0;
        m_valid = 1'b0;
        m_flush = 1'b0;
        m_kill  = 1'b0;
        m_pend.delete();
        wait_cnt = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("req",      32'(out_imem_req), 32'(m_state == M_FETCH));
        check("addr",     out_imem_addr, m_pc);
        check("if_valid", 32'(out_if_valid), 32'(m_valid));
        check("if_instr", out_if_instr, m_instr);
        check("if_pc",    out_if_pc, m_ifpc);
        check("flush",    32'(out_flush), 32'(m_flush));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input bit stall, input bit br, input logic [31:0] tgt, input bit exc);
        logic        fetching;
        logic        ack;
        logic        got;
        logic [31:0] tgt_al;
        int          ns;
        fetching = (m_state == M_FETCH);
        ack      = ack_force || (fetching && (wait_cnt >= lat - 1));
        got      = fetching && ack;
        tgt_al   = {tgt[31:2], 2'b00};

        in_stall         = stall;
        in_branch        = br;
        in_branch_target = tgt;
        in_exception     = exc;
        in_imem_ack      = ack;
        in_imem_data     = mem_word(out_imem_addr);

        ns = m_state;
        if (m_state == M_IDLE) ns = M_FETCH;
        else if (m_state == M_FETCH) begin
            if (ack) ns = stall ? M_HOLD : M_FETCH;
        end else if (!stall) ns = M_FETCH;

        m_flush = exc;
        if (exc) begin
            m_pend.delete();
            m_valid = 1'b0;
            if (fetching && !ack) m_kill = 1'b1;
            else begin
                m_kill = 1'b0;
                m_pc   = EXC_PC;
            end
        end else if (got && m_kill) begin
            m_kill = 1'b0;
            m_pc   = EXC_PC;
        end else if (got) begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            if (br) begin
                m_pc = tgt_al;
                m_pend.delete();
            end else if (m_pend.size() > 0) m_pc = m_pend.pop_front();
            else m_pc = m_pc + 32'd4;
        end else if (br && !m_kill) begin
            if (fetching) begin
                m_pend.delete();
                m_pend.push_back(tgt_al);
            end else m_pc = tgt_al;
        end
        m_state = ns;

        if (fetching && !ack) wait_cnt++;
        else wait_cnt = 0;

        @(posedge in_clk);
        #1;
        check_model();
    endtask

    initial begin
        bit prev_br;
        bit prev_exc;
        bit r_stall;
        bit r_br;
        bit r_exc;

        n_vec = 0;
        n_err = 0;
        lat = 1;
        ack_force = 1'b0;
        in_rst = 1'b0;
        in_stall = 1'b0;
        in_branch = 1'b0;
        in_branch_target = 32'h0;
        in_exception = 1'b0;
        in_imem_ack = 1'b0;
        in_imem_data = 32'h0;
        model_reset();

        repeat (2) @(posedge in_clk);
        #1;
        check_model();
        check("rst_req", 32'(out_imem_req), 32'h0);
        check("rst_instr", out_if_instr, 32'h0);
        in_rst = 1'b1;

        // Sequential fetch with single-cycle memory
        step(0, 0, 32'h0, 0);
        check("first_addr", out_imem_addr, 32'h0040_0000);
        step(0, 0, 32'h0, 0);
        check("valid_rise", 32'(out_if_valid), 32'h1);
        check("addr2", out_imem_addr, 32'h0040_0004);
        step(0, 0, 32'h0, 0);
        check("addr3", out_imem_addr, 32'h0040_0008);

        // Branch: 0x00400008 is the delay slot
        step(0, 1, 32'h0040_0100, 0);
        check("delay_slot_pc", out_if_pc, 32'h0040_0008);
        check("branch_addr", out_imem_addr, 32'h0040_0100);
        check("branch_noflush", 32'(out_flush), 32'h0);
        step(0, 1, 32'h0040_000C, 0);
        check("to_0c", out_imem_addr, 32'h0040_000C);

        // Exception during a slow fetch: ack data discarded
        lat = 3;
        step(0, 0, 32'h0, 1);
        check("exc_flush", 32'(out_flush), 32'h1);
        check("exc_valid", 32'(out_if_valid), 32'h0);
        check("exc_addr_stable", out_imem_addr, 32'h0040_000C);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check("killed_next", out_imem_addr, 32'h0040_0004);
        check("killed_valid", 32'(out_if_valid), 32'h0);
        repeat (3) step(0, 0, 32'h0, 0);
        check("exc_vec_pc", out_if_pc, 32'h0040_0004);
        check("exc_vec_valid", 32'(out_if_valid), 32'h1);

        // Simultaneous branch and exception
        lat = 1;
        step(0, 1, 32'h0040_0200, 1);
        check("both_addr", out_imem_addr, 32'h0040_0004);
        check("both_flush", 32'(out_flush), 32'h1);
        step(0, 0, 32'h0, 0);
        check("both_next", out_imem_addr, 32'h0040_0008);

        // Stall held four cycles after an ack
        step(1, 0, 32'h0, 0);
        check("hold_pc", out_if_pc, 32'h0040_0008);
`ifdef FETCH_PERF_CNT_EN
        stall_snap = out_stall_cnt;
`endif
        repeat (3) begin
            step(1, 0, 32'h0, 0);
            check("hold_req", 32'(out_imem_req), 32'h0);
            check("hold_pc_frozen", out_if_pc, 32'h0040_0008);
        end
        step(0, 0, 32'h0, 0);
        check("resume_addr", out_imem_addr, 32'h0040_000C);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", out_stall_cnt - stall_snap, 32'd4);
`endif

        // Address wrap
        step(0, 1, 32'hFFFF_FFFF, 0);
        check("wrap_tgt", out_imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0);
        check("wrap_zero", out_imem_addr, 32'h0000_0000);
        check("wrap_pc", out_if_pc, 32'hFFFF_FFFC);

        // Newer pending target overwrites the older one
        lat = 4;
        step(0, 1, 32'h0040_1000, 0);
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0040_2000, 0);
        step(0, 0, 32'h0, 0);
        check("pend_overwrite", out_imem_addr, 32'h0040_2000);

        // Stall with branch still latches the target
        lat = 3;
        step(1, 1, 32'h0040_3000, 0);
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        check("stall_br_addr", out_imem_addr, 32'h0040_3000);
        step(0, 0, 32'h0, 0);
        check("stall_br_req", 32'(out_imem_req), 32'h1);

        // Reset mid-fetch with a late ack
        step(0, 0, 32'h0, 0);
        in_rst = 1'b0;
        #1;
        check("rst_drop_req", 32'(out_imem_req), 32'h0);
        model_reset();
        in_imem_ack = 1'b1;
        @(posedge in_clk);
        #1;
        check_model();
        in_rst = 1'b1;
        ack_force = 1'b1;
        step(0, 0, 32'h0, 0);
        ack_force = 1'b0;
        check("late_ack_ignored", 32'(out_if_valid), 32'h0);
        lat = 2;
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check("post_rst_pc", out_if_pc, 32'h0040_0000);

        // Random traffic
        prev_br = 1'b0;
        prev_exc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) lat = int'($urandom_range(1, 3));
            r_stall = ($urandom_range(0, 4) == 0);
            r_br    = !prev_br && ($urandom_range(0, 9) == 0);
            r_exc   = !prev_exc && ($urandom_range(0, 24) == 0);
            step(r_stall, r_br, $urandom(), r_exc);
            prev_br  = r_br;
            prev_exc = r_exc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
